// File: rtl/sequence_detector_pkg.sv
// Shared types and constants for the programmable serial sequence detector.
//   state_e    : detector FSM state (IDLE / FILL / RUN), 2-bit encoding
//   seq_cfg_t  : run-time configuration {pattern, length, overlap}; fields are
//                sized for the largest supported MAX_LEN (32) and the top only
//                consumes the low MAX_LEN / LEN_W bits
//   DEF_*      : configuration loaded at reset
package sequence_detector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int unsigned CFG_PAT_W = 32;
  localparam int unsigned CFG_LEN_W = 6;

  localparam logic [7:0]  DEF_PATTERN = 8'b0000_1011;
  localparam int unsigned DEF_LENGTH  = 4;
  localparam bit          DEF_OVERLAP = 1'b1;

  typedef struct packed {
    logic [CFG_PAT_W-1:0] pattern;
    logic [CFG_LEN_W-1:0] length;
    logic                 overlap;
  } seq_cfg_t;

endpackage

// File: rtl/sequence_detector_param_match.sv
// seq_match_compare: combinational masked compare of the receive window
// against the programmed pattern, over the low length_i bits only.
//   window_i  : {history, current bit}; bit 0 is the newest bit
//   pattern_i : right-aligned pattern, bit [L-1] is the oldest bit
//   length_i  : active pattern length L
//   hit_o     : 1 when window_i[L-1:0] == pattern_i[L-1:0]
module seq_match_compare #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] window_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   length_i,
  output logic               hit_o
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) mask[i] = (i < int'(length_i));
  end

  assign hit_o = ~|((window_i ^ pattern_i) & mask);

endmodule

// File: rtl/sequence_detector_param.sv
// sequence_detector_param: run-time programmable serial bit-pattern detector.
//   clock_i / reset_ni   : rising-edge clock, async active-low reset
//   enable_i             : detection enable (low returns to IDLE)
//   sequence_valid_i     : qualifies sequence_i
//   sequence_i           : serial data bit
//   cfg_load_i           : one-cycle config load strobe with
//                          cfg_pattern_i / cfg_length_i / cfg_overlap_i
//   detector_o           : registered one-cycle match pulse
//   match_count_o        : saturating match count
//   cfg_error_o          : one-cycle pulse on a rejected load (length 0 or > MAX_LEN)
//   active_o             : high in FILL or RUN
// MAX_LEN must be in 2..32.
module sequence_detector_param
  import sequence_detector_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int unsigned DEFAULT_LENGTH  = DEF_LENGTH,
  parameter bit          DEFAULT_OVERLAP = DEF_OVERLAP,
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   enable_i,
  input  logic                   sequence_valid_i,
  input  logic                   sequence_i,
  input  logic                   cfg_load_i,
  input  logic [MAX_LEN-1:0]     cfg_pattern_i,
  input  logic [LEN_W-1:0]       cfg_length_i,
  input  logic                   cfg_overlap_i,
  output logic                   detector_o,
  output logic [COUNT_WIDTH-1:0] match_count_o,
  output logic                   cfg_error_o,
  output logic                   active_o
);

  state_e                 state_q, state_d;
  logic [MAX_LEN-1:0]     hist_q, hist_d;
  logic [LEN_W-1:0]       fill_q, fill_d;
  seq_cfg_t               cfg_q, cfg_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   det_q, det_d;
  logic                   err_q, err_d;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len, len_m1;
  logic               cfg_ok, accept, full, hit, match;

  // Config fields are sized for the widest build; the upper bits and the
  // oldest history bit never feed logic.
  logic unused_bits;
  assign unused_bits = ^{cfg_q, hist_q[MAX_LEN-1]};

  assign cfg_pat = cfg_q.pattern[MAX_LEN-1:0];
  assign cfg_len = cfg_q.length[LEN_W-1:0];
  assign len_m1  = cfg_len - LEN_W'(1);
  assign window  = {hist_q[MAX_LEN-2:0], sequence_i};
  assign cfg_ok  = (cfg_length_i != '0) && (cfg_length_i <= LEN_W'(MAX_LEN));

  // A bit presented alongside cfg_load is always dropped, accepted or not.
  assign accept  = enable_i && sequence_valid_i && !cfg_load_i &&
                   (state_q == FILL || state_q == RUN);
  assign full    = (fill_q >= len_m1);
  assign match   = accept && full && hit;

  seq_match_compare #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .window_i  (window),
    .pattern_i (cfg_pat),
    .length_i  (cfg_len),
    .hit_o     (hit)
  );

  // State register (also holds the datapath registers)
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      hist_q        <= '0;
      fill_q        <= '0;
      cfg_q.pattern <= CFG_PAT_W'(DEFAULT_PATTERN);
      cfg_q.length  <= CFG_LEN_W'(DEFAULT_LENGTH);
      cfg_q.overlap <= DEFAULT_OVERLAP;
      cnt_q         <= '0;
      det_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    det_d   = 1'b0;
    err_d   = 1'b0;

    if (match) begin
      det_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + COUNT_WIDTH'(1);
    end

    if (cfg_load_i) begin
      if (cfg_ok) begin
        cfg_d.pattern                = '0;
        cfg_d.pattern[MAX_LEN-1:0]   = cfg_pattern_i;
        cfg_d.length                 = CFG_LEN_W'(cfg_length_i);
        cfg_d.overlap                = cfg_overlap_i;
        hist_d                       = '0;
        fill_d                       = '0;
        cnt_d                        = '0;
        state_d                      = enable_i ? FILL : IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_d = FILL;
            hist_d  = '0;
            fill_d  = '0;
          end
        end
        FILL, RUN: begin
          if (!enable_i) begin
            state_d = IDLE;
            hist_d  = '0;
            fill_d  = '0;
          end else if (accept) begin
            if (match && !cfg_q.overlap) begin
              // Non-overlapping: the next match needs L fresh bits.
              state_d = FILL;
              hist_d  = '0;
              fill_d  = '0;
            end else begin
              hist_d = window;
              if (full) state_d = RUN;
              else      fill_d  = fill_q + LEN_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    active_o = (state_q == FILL) || (state_q == RUN);
  end

  assign detector_o    = det_q;
  assign match_count_o = cnt_q;
  assign cfg_error_o   = err_q;

endmodule

// File: tb/tb_sequence_detector_param.sv
module tb_sequence_detector_param;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic             enable = 1'b0, seq_valid = 1'b0, seq_bit = 1'b0;
  logic             cfg_load = 1'b0, cfg_overlap = 1'b0;
  logic [7:0]       cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_length = '0;

  logic       det_a, err_a, act_a;
  logic [7:0] cnt_a;
  logic       det_b, err_b, act_b;
  logic [1:0] cnt_b;

  always #5 clock = ~clock;

  sequence_detector_param #(.MAX_LEN(MAX_LEN), .COUNT_WIDTH(8)) dut_a (
    .clock_i(clock), .reset_ni(reset_n), .enable_i(enable),
    .sequence_valid_i(seq_valid), .sequence_i(seq_bit),
    .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
    .cfg_length_i(cfg_length), .cfg_overlap_i(cfg_overlap),
    .detector_o(det_a), .match_count_o(cnt_a),
    .cfg_error_o(err_a), .active_o(act_a)
  );

  sequence_detector_param #(.MAX_LEN(MAX_LEN), .COUNT_WIDTH(2)) dut_b (
    .clock_i(clock), .reset_ni(reset_n), .enable_i(enable),
    .sequence_valid_i(seq_valid), .sequence_i(seq_bit),
    .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
    .cfg_length_i(cfg_length), .cfg_overlap_i(cfg_overlap),
    .detector_o(det_b), .match_count_o(cnt_b),
    .cfg_error_o(err_b), .active_o(act_b)
  );

  // Reference model: the accepted bits since the last clear, kept as a queue;
  // a match is "the last L received bits spell the pattern".
  bit         m_run;
  bit         m_q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt_a, m_cnt_b;
  bit         m_det, m_err;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_run = 0; m_q.delete();
    m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1;
    m_cnt_a = 0; m_cnt_b = 0; m_det = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit hit;
    m_det = 0; m_err = 0;
    if (cfg_load) begin
      if (cfg_length >= 1 && int'(cfg_length) <= MAX_LEN) begin
        m_pat = cfg_pattern; m_len = int'(cfg_length); m_ovl = cfg_overlap;
        m_q.delete(); m_cnt_a = 0; m_cnt_b = 0; m_run = enable;
      end else m_err = 1;
    end else if (!m_run) begin
      m_run = enable; m_q.delete();
    end else if (!enable) begin
      m_run = 0; m_q.delete();
    end else if (seq_valid) begin
      m_q.push_back(seq_bit);
      if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
      hit = (m_q.size() >= m_len);
      if (hit)
        for (int i = 0; i < m_len; i++)
          if (m_q[m_q.size() - 1 - i] != m_pat[i]) hit = 0;
      if (hit) begin
        m_det = 1;
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3)   m_cnt_b++;
        if (!m_ovl) m_q.delete();
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".det_a"}, {31'b0, det_a}, {31'b0, m_det});
    chk({tag, ".cnt_a"}, {24'b0, cnt_a}, m_cnt_a);
    chk({tag, ".err_a"}, {31'b0, err_a}, {31'b0, m_err});
    chk({tag, ".act_a"}, {31'b0, act_a}, {31'b0, m_run});
    chk({tag, ".det_b"}, {31'b0, det_b}, {31'b0, m_det});
    chk({tag, ".cnt_b"}, {30'b0, cnt_b}, m_cnt_b);
  endtask

  task automatic cyc(input string tag, input logic en, input logic vld, input logic b,
                     input logic ld, input logic [7:0] pat, input logic [LEN_W-1:0] len,
                     input logic ovl);
    enable = en; seq_valid = vld; seq_bit = b;
    cfg_load = ld; cfg_pattern = pat; cfg_length = len; cfg_overlap = ovl;
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic bit_in(input string tag, input logic b);
    cyc(tag, 1'b1, 1'b1, b, 1'b0, 8'h00, '0, 1'b0);
  endtask

  task automatic load(input string tag, input logic [7:0] pat, input logic [LEN_W-1:0] len,
                      input logic ovl);
    cyc(tag, 1'b1, 1'b0, 1'b0, 1'b1, pat, len, ovl);
  endtask

  task automatic bits(input string tag, input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(tag, v[i]);
  endtask

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // 1: default 1011 overlapping
    cyc("t1_idle", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0, 1'b0);
    bits("t1", 16'b1011011, 7);
    chk("t1_count", {24'b0, cnt_a}, 32'd2);

    // 2: non-overlapping
    load("t2_load", 8'b1011, 4'd4, 1'b0);
    bits("t2", 16'b1011011, 7);
    chk("t2_count", {24'b0, cnt_a}, 32'd1);

    // 3: valid gaps with sequence toggling underneath
    load("t3_load", 8'b1011, 4'd4, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      bit_in("t3_bit", 1'((4'b1011 >> i) & 1));
      for (int g = 0; g < 3; g++) cyc("t3_gap", 1'b1, 1'b0, 1'(g & 1), 1'b0, 8'h00, '0, 1'b0);
    end
    chk("t3_count", {24'b0, cnt_a}, 32'd1);

    // 4: L = MAX_LEN, then a rejected load
    load("t4_load", 8'hA5, 4'd8, 1'b1);
    bits("t4", 16'hA5A5, 16);
    chk("t4_count", {24'b0, cnt_a}, 32'd2);
    load("t4_bad", 8'hFF, 4'd0, 1'b0);
    chk("t4_err", {31'b0, err_a}, 32'd1);
    bits("t4_after", 16'h00A5, 8);
    chk("t4_count2", {24'b0, cnt_a}, 32'd3);
    load("t4_bad9", 8'h00, 4'd9, 1'b0);

    // 5: L = 1, back-to-back, 2-bit counter saturates
    load("t5_load", 8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) bit_in("t5", 1'b1);
    chk("t5_cnt_b", {30'b0, cnt_b}, 32'd3);
    chk("t5_cnt_a", {24'b0, cnt_a}, 32'd6);

    // 6: reset mid-stream
    load("t6_load", 8'b1011, 4'd4, 1'b1);
    bits("t6", 16'b101, 3);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("t6_reset");
    @(negedge clock);
    reset_n = 1'b1;
    cyc("t6_idle", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0, 1'b0);
    bit_in("t6_bit", 1'b1);
    chk("t6_count", {24'b0, cnt_a}, 32'd0);
    chk("t6_active", {31'b0, act_a}, 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic en, vld, b, ld, ovl;
      logic [7:0] pat;
      logic [LEN_W-1:0] len;
      en  = ($urandom_range(0, 19) != 0);
      vld = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom);
      ld  = ($urandom_range(0, 29) == 0);
      pat = 8'($urandom);
      ovl = 1'($urandom);
      len = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 10))
                                        : LEN_W'($urandom_range(1, 4));
      cyc("rand", en, vld, b, ld, pat, len, ovl);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
